image_window_control: RTL

Read-side controller for the edge-detection line buffering. It accepts a raster stream of 8-bit grayscale pixels into four rotating line stores, each IMAGE_WIDTH deep. Once three lines are stored, it reads them back as a stream of 3x3 pixel windows, one per cycle, to feed the convolution stage. It also raises a one-cycle interrupt each time a line has been consumed, so the upstream DMA can send the next line.

---
 rtl/image_window_control.sv | 114 +++++++++++
 1 files changed

// File: rtl/image_window_control.sv
// Line-buffer read controller: stores a raster stream in four rotating line stores
// and emits one 3x3 window per cycle once three lines are held.
//
// state | meaning
// IDLE  | waiting for three full lines; the leaving edge loads window 0
// READ  | loading windows 1..IMAGE_WIDTH-3 of the current read line
module image_window_control #(
  parameter int IMAGE_WIDTH = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_data_valid,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_intr
);

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int PW = $clog2(4 * IMAGE_WIDTH + 1);
  localparam logic [CW-1:0] LAST_WCOL = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] LAST_RCOL = CW'(IMAGE_WIDTH - 3);
  localparam logic [PW-1:0] READY_CNT = PW'(3 * IMAGE_WIDTH);
  localparam logic [PW-1:0] FULL_CNT  = PW'(4 * IMAGE_WIDTH);
  localparam logic [PW-1:0] LINE_CNT  = PW'(IMAGE_WIDTH);

  typedef enum logic {IDLE, READ} state_t;
  state_t state, state_next;

  logic [7:0]    line_mem [4][IMAGE_WIDTH];
  logic [1:0]    wsel, rsel, msel, bsel;
  logic [CW-1:0] wcol, rcol, rcol_next, col1, col2;
  logic [PW-1:0] pixel_count;
  logic          wr_en, load, line_done;
  logic [71:0]   window;

  // A write with all four stores occupied is dropped outright.
  assign wr_en = i_pixel_data_valid && (pixel_count != FULL_CNT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    line_done  = 1'b0;
    rcol_next  = rcol;
    case (state)
      IDLE: begin
        if (pixel_count >= READY_CNT) begin
          load       = 1'b1;
          rcol_next  = CW'(1);
          state_next = READ;
        end
      end
      READ: begin
        load = 1'b1;
        if (rcol == LAST_RCOL) begin
          line_done  = 1'b1;
          rcol_next  = '0;
          state_next = IDLE;
        end else begin
          rcol_next = rcol + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Store contents are never reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) line_mem[wsel][wcol] <= i_pixel_data;
  end

  assign msel = rsel + 2'd1;
  assign bsel = rsel + 2'd2;
  assign col1 = rcol + CW'(1);
  assign col2 = rcol + CW'(2);

  assign window = {line_mem[rsel][rcol], line_mem[rsel][col1], line_mem[rsel][col2],
                   line_mem[msel][rcol], line_mem[msel][col1], line_mem[msel][col2],
                   line_mem[bsel][rcol], line_mem[bsel][col1], line_mem[bsel][col2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      wcol               <= '0;
      wsel               <= '0;
      rcol               <= '0;
      rsel               <= '0;
      pixel_count        <= '0;
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wcol == LAST_WCOL) begin
          wcol <= '0;
          wsel <= wsel + 2'd1;
        end else begin
          wcol <= wcol + CW'(1);
        end
      end
      pixel_count <= pixel_count + PW'(wr_en) - (line_done ? LINE_CNT : '0);
      rcol               <= rcol_next;
      o_pixel_data_valid <= load;
      o_intr             <= line_done;
      if (load)      o_pixel_data <= window;
      if (line_done) rsel         <= rsel + 2'd1;
    end
  end

endmodule
